div16_8_seq: RTL and testbench
==============================

DIV16_8_SEQ -- requirements
Module: div16_8_seq

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Port in_valid  input  1  request valid.
REQ-005 Port in_ready  output  1  block can accept a request.
REQ-006 Port dividend  input  16  unsigned dividend, i.e. the full width of an 8x8 product.
REQ-007 Port divisor  input  8  unsigned divisor.
REQ-008 Port out_valid  output  1  result valid.
REQ-009 Port out_ready  input  1  consumer accepts the result.
REQ-010 Port quotient  output  16  unsigned quotient.
REQ-011 Port remainder  output  8  unsigned remainder.
REQ-012 Port div_zero  output  1  the result came from a zero divisor.

Function
REQ-013 The block SHALL be an exact restoring divider that retires 1 quotient bit per cycle, MSB first; the block SHALL be the inverse operation of the team's 8x8 multipliers.
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 out_valid SHALL be 1 only in DONE.
REQ-017 Accept SHALL occur at a rising edge where in_valid=1 and in_ready=1.
REQ-018 On accept, the block SHALL capture dividend and divisor into internal registers.
REQ-019 On accept with divisor!=0, the block SHALL clear the partial remainder (9 bits), load bit counter=15 and go to CALC.
REQ-020 On accept with divisor=0, the block SHALL go directly to DONE with quotient=16'hFFFF, remainder=dividend[7:0] and div_zero=1.
REQ-021 Each CALC cycle SHALL form t = {partial remainder[7:0], dividend bit[counter]}.
REQ-022 If t >= divisor, the block SHALL set partial remainder = t - divisor and quotient bit[counter] = 1; otherwise it SHALL set partial remainder = t and quotient bit[counter] = 0.
REQ-023 The counter SHALL decrement by one each CALC cycle.
REQ-024 When the counter is 0 in CALC, the block SHALL go to DONE on that edge, after exactly 16 CALC cycles.
REQ-025 Latency (divisor!=0): out_valid SHALL be 1 in the cycle after the 16th CALC edge, i.e. 17 rising edges after and including the accept edge.
REQ-026 Latency (divisor=0): out_valid SHALL be 1 in the cycle after the accept edge.
REQ-027 In DONE, quotient, remainder and div_zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 On the edge where out_valid=1 and out_ready=1, the block SHALL go to IDLE.
REQ-029 A new request SHALL NOT be accepted on the same edge as a result handshake, because in_ready=0 in DONE.
REQ-030 quotient and remainder SHALL only be guaranteed meaningful when out_valid=1.
REQ-031 The outputs SHALL keep their last values in IDLE and CALC.
REQ-032 The block SHALL always produce remainder < divisor when divisor!=0.
REQ-033 The block SHALL guarantee dividend = quotient*divisor + remainder, with quotient<=16'hFFFF.
REQ-034 in_valid and the input data SHALL be ignored in CALC and DONE.
REQ-035 The block SHALL NOT perform input buffering.

Reset
REQ-036 When rst=1 at a rising edge, the state SHALL become IDLE.
REQ-037 On that reset edge, out_valid SHALL be set to 0 and in_ready SHALL be 1 from the next cycle.
REQ-038 On that reset edge, quotient, remainder, div_zero and the counter SHALL be set to 0.
REQ-039 Reset SHALL take priority over accept and handshake on the same edge.
REQ-040 Reset in CALC or DONE SHALL abort the operation and discard its result.

Verification
REQ-041 The bench SHALL apply dividend=1000, divisor=7 -> required: quotient=142, remainder=6, div_zero=0, out_valid at accept+17 edges.
REQ-042 The bench SHALL apply dividend=16'hFFFF, divisor=255 -> required: quotient=257, remainder=0; then 16'hFE01/255 -> required: quotient=255, remainder=0.
REQ-043 The bench SHALL apply dividend=5, divisor=0 -> required: quotient=16'hFFFF, remainder=5, div_zero=1, out_valid 1 cycle after accept.
REQ-044 The bench SHALL apply dividend=0, divisor=1, with out_ready held 0 for 5 cycles after out_valid -> required: quotient=0, remainder=0 stable; in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-045 The bench SHALL assert rst at the 8th CALC cycle of 1000/7 -> required: next cycle out_valid=0, in_ready=1, outputs 0; a following 200/3 returns quotient=66, remainder=2.
REQ-046 The bench SHALL run a random sweep of all divisors 1..255 with random dividends, with back-to-back in_valid -> required: every result satisfies REQ-032 and REQ-033, with no lost or duplicated transactions.

Source files
------------

// File: rtl/div16_8_seq_if.sv
// div16_8_seq_if -- request/result handshake bundle for the 16/8 divider.
//   in_valid/in_ready + dividend/divisor : request side
//   out_valid/out_ready + quotient/remainder/div_zero : result side
// master: the requester/consumer; slave: the divider.
interface div16_8_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div16_8_seq.sv
// div16_8_seq -- sequential restoring divider, 16-bit dividend / 8-bit divisor,
// one quotient bit per cycle, MSB first.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   s_div : request/result bundle (slave modport of div16_8_seq_if)
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// CALC  | retiring one quotient bit per cycle, counter 15..0
// DONE  | result presented, out_valid=1 until out_ready
module div16_8_seq (
  input  logic         clk,
  input  logic         rst,
  div16_8_seq_if.slave s_div
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_dividend;
  logic [7:0]  r_divisor;
  logic [7:0]  r_rem;
  logic [15:0] r_quot_work;
  logic [3:0]  r_cnt;
  logic [15:0] r_quot;
  logic [7:0]  r_rem_out;
  logic        r_div_zero;

  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_accept;
  logic [8:0]  w_t;
  logic        w_ge;
  logic [7:0]  w_diff;
  logic [7:0]  w_rem_nxt;
  logic [15:0] w_quot_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (s_div.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (s_div.divisor == 8'd0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_cnt == 4'd0) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (s_div.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The 9-bit trial value t can exceed 255, but whenever t >= divisor the true
  // difference is below the divisor, so the 8-bit wrapped subtraction is exact.
  always_comb begin
    w_t        = {r_rem, r_dividend[r_cnt]};
    w_ge       = (w_t >= {1'b0, r_divisor});
    w_diff     = w_t[7:0] - r_divisor;
    w_rem_nxt  = w_ge ? w_diff : w_t[7:0];
    w_quot_nxt = r_quot_work;
    w_quot_nxt[r_cnt] = w_ge;
  end

  // Working quotient is kept apart from the output register so the visible
  // result only changes when a division completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dividend  <= 16'd0;
      r_divisor   <= 8'd0;
      r_rem       <= 8'd0;
      r_quot_work <= 16'd0;
      r_cnt       <= 4'd0;
      r_quot      <= 16'd0;
      r_rem_out   <= 8'd0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dividend  <= s_div.dividend;
            r_divisor   <= s_div.divisor;
            r_rem       <= 8'd0;
            r_quot_work <= 16'd0;
            r_cnt       <= 4'd15;
            if (s_div.divisor == 8'd0) begin
              r_quot     <= 16'hFFFF;
              r_rem_out  <= s_div.dividend[7:0];
              r_div_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          r_rem       <= w_rem_nxt;
          r_quot_work <= w_quot_nxt;
          r_cnt       <= r_cnt - 4'd1;
          if (r_cnt == 4'd0) begin
            r_quot     <= w_quot_nxt;
            r_rem_out  <= w_rem_nxt;
            r_div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_div.in_ready  = w_in_ready;
  assign s_div.out_valid = w_out_valid;
  assign s_div.quotient  = r_quot;
  assign s_div.remainder = r_rem_out;
  assign s_div.div_zero  = r_div_zero;

endmodule

// File: tb/tb_div16_8_seq.sv
// tb_div16_8_seq -- self-checking bench for div16_8_seq.
// Reference results come from plain integer division (/ and %).
module tb_div16_8_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div16_8_seq_if u_if ();

  div16_8_seq dut (
    .clk   (clk),
    .rst   (rst),
    .s_div (u_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
  } req_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one request in IDLE, then waits (bounded) for out_valid.
  // lat = edges after the accept edge until out_valid is seen.
  task automatic start_and_wait(input logic [15:0] dd, input logic [7:0] dv,
                                output int lat, output bit ok);
    ok = u_if.in_ready;
    u_if.dividend = dd;
    u_if.divisor  = dv;
    u_if.in_valid = 1'b1;
    tick;
    u_if.in_valid = 1'b0;
    u_if.dividend = 16'($urandom);
    u_if.divisor  = 8'($urandom);
    lat = 0;
    while (!u_if.out_valid && lat < 40) begin
      tick;
      lat++;
    end
    if (!u_if.out_valid) ok = 1'b0;
  endtask

  task automatic handshake;
    u_if.out_ready = 1'b1;
    tick;
    u_if.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    u_if.dividend  = 16'd0;
    u_if.divisor   = 8'd0;
    tick;
    tick;
    rst = 1'b0;
    n_checks++;
    if (u_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", u_if.out_valid); end
    n_checks++;
    if (u_if.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", u_if.in_ready); end
    n_checks++;
    if (u_if.quotient !== 16'd0) begin n_errors++; $display("FAIL reset_quotient: got %h want 0", u_if.quotient); end
    n_checks++;
    if (u_if.remainder !== 8'd0) begin n_errors++; $display("FAIL reset_remainder: got %h want 0", u_if.remainder); end
    n_checks++;
    if (u_if.div_zero !== 1'b0) begin n_errors++; $display("FAIL reset_div_zero: got %b want 0", u_if.div_zero); end
  endtask

  task automatic test_basic;
    int lat;
    bit ok;
    start_and_wait(16'd1000, 8'd7, lat, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL basic_accept_or_timeout: got ok=%0d want 1", ok); end
    n_checks++;
    if (lat != 16) begin n_errors++; $display("FAIL basic_latency: got %0d edges after accept want 16", lat); end
    n_checks++;
    if (u_if.quotient !== 16'd142) begin n_errors++; $display("FAIL basic_quotient: got %0d want 142", u_if.quotient); end
    n_checks++;
    if (u_if.remainder !== 8'd6) begin n_errors++; $display("FAIL basic_remainder: got %0d want 6", u_if.remainder); end
    n_checks++;
    if (u_if.div_zero !== 1'b0) begin n_errors++; $display("FAIL basic_div_zero: got %b want 0", u_if.div_zero); end
    n_checks++;
    if (u_if.in_ready !== 1'b0) begin n_errors++; $display("FAIL basic_in_ready_done: got %b want 0", u_if.in_ready); end
    handshake;
    n_checks++;
    if (u_if.in_ready !== 1'b1 || u_if.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL basic_idle_after_hs: got in_ready=%b out_valid=%b want 1/0", u_if.in_ready, u_if.out_valid);
    end
  endtask

  task automatic test_boundary;
    req_t tbl [4];
    logic [15:0] exp_q [4];
    logic [7:0]  exp_r [4];
    tbl[0] = '{16'hFFFF, 8'd255}; exp_q[0] = 16'd257;   exp_r[0] = 8'd0;
    tbl[1] = '{16'hFE01, 8'd255}; exp_q[1] = 16'd255;   exp_r[1] = 8'd0;
    tbl[2] = '{16'hFFFF, 8'd1};   exp_q[2] = 16'hFFFF;  exp_r[2] = 8'd0;
    tbl[3] = '{16'h00FE, 8'd255}; exp_q[3] = 16'd0;     exp_r[3] = 8'd254;
    for (int i = 0; i < 4; i++) begin
      int lat;
      bit ok;
      start_and_wait(tbl[i].dd, tbl[i].dv, lat, ok);
      n_checks++;
      if (!ok || lat != 16) begin n_errors++; $display("FAIL boundary_%0d_latency: got ok=%0d lat=%0d want 1/16", i, ok, lat); end
      n_checks++;
      if (u_if.quotient !== exp_q[i]) begin n_errors++; $display("FAIL boundary_%0d_quotient: got %0d want %0d", i, u_if.quotient, exp_q[i]); end
      n_checks++;
      if (u_if.remainder !== exp_r[i]) begin n_errors++; $display("FAIL boundary_%0d_remainder: got %0d want %0d", i, u_if.remainder, exp_r[i]); end
      handshake;
    end
  endtask

  task automatic test_div_zero;
    int lat;
    bit ok;
    start_and_wait(16'd5, 8'd0, lat, ok);
    n_checks++;
    if (!ok || lat != 0) begin n_errors++; $display("FAIL divzero_latency: got ok=%0d lat=%0d want 1/0", ok, lat); end
    n_checks++;
    if (u_if.quotient !== 16'hFFFF) begin n_errors++; $display("FAIL divzero_quotient: got %h want ffff", u_if.quotient); end
    n_checks++;
    if (u_if.remainder !== 8'd5) begin n_errors++; $display("FAIL divzero_remainder: got %0d want 5", u_if.remainder); end
    n_checks++;
    if (u_if.div_zero !== 1'b1) begin n_errors++; $display("FAIL divzero_flag: got %b want 1", u_if.div_zero); end
    handshake;
  endtask

  task automatic test_reset_mid;
    int lat;
    bit ok;
    u_if.dividend = 16'd1000;
    u_if.divisor  = 8'd7;
    u_if.in_valid = 1'b1;
    tick;
    u_if.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    n_checks++;
    if (u_if.in_ready !== 1'b0 || u_if.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL resetmid_busy: got in_ready=%b out_valid=%b want 0/0", u_if.in_ready, u_if.out_valid);
    end
    n_checks++;
    if (u_if.quotient !== 16'hFFFF || u_if.div_zero !== 1'b1) begin
      n_errors++; $display("FAIL resetmid_hold_in_calc: got q=%h dz=%b want ffff/1", u_if.quotient, u_if.div_zero);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++;
    if (u_if.out_valid !== 1'b0 || u_if.in_ready !== 1'b1) begin
      n_errors++; $display("FAIL resetmid_state: got out_valid=%b in_ready=%b want 0/1", u_if.out_valid, u_if.in_ready);
    end
    n_checks++;
    if (u_if.quotient !== 16'd0 || u_if.remainder !== 8'd0 || u_if.div_zero !== 1'b0) begin
      n_errors++; $display("FAIL resetmid_outputs: got q=%h r=%h dz=%b want 0/0/0", u_if.quotient, u_if.remainder, u_if.div_zero);
    end
    start_and_wait(16'd200, 8'd3, lat, ok);
    n_checks++;
    if (!ok || lat != 16) begin n_errors++; $display("FAIL resetmid_next_latency: got ok=%0d lat=%0d want 1/16", ok, lat); end
    n_checks++;
    if (u_if.quotient !== 16'd66 || u_if.remainder !== 8'd2) begin
      n_errors++; $display("FAIL resetmid_next_result: got q=%0d r=%0d want 66/2", u_if.quotient, u_if.remainder);
    end
    handshake;
  endtask

  task automatic test_hold;
    int lat;
    bit ok;
    start_and_wait(16'd0, 8'd1, lat, ok);
    n_checks++;
    if (!ok || lat != 16) begin n_errors++; $display("FAIL hold_latency: got ok=%0d lat=%0d want 1/16", ok, lat); end
    // Drive a competing request while the result waits; it must be ignored.
    u_if.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      u_if.dividend = 16'($urandom);
      u_if.divisor  = 8'($urandom_range(1, 255));
      n_checks++;
      if (u_if.out_valid !== 1'b1 || u_if.in_ready !== 1'b0 || u_if.quotient !== 16'd0 || u_if.remainder !== 8'd0) begin
        n_errors++;
        $display("FAIL hold_cycle_%0d: got ov=%b ir=%b q=%0d r=%0d want 1/0/0/0", i,
                 u_if.out_valid, u_if.in_ready, u_if.quotient, u_if.remainder);
      end
      tick;
    end
    handshake;
    n_checks++;
    if (u_if.in_ready !== 1'b1 || u_if.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL hold_idle_after_hs: got in_ready=%b out_valid=%b want 1/0", u_if.in_ready, u_if.out_valid);
    end
    u_if.in_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    req_t        items [255];
    req_t        exp_q [$];
    req_t        e;
    int          sent = 0;
    int          got = 0;
    int          cycles = 0;
    bit          acc;
    bit          hs;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    for (int i = 0; i < 255; i++) begin
      items[i].dd = (i % 17 == 0) ? 16'hFFFF : 16'($urandom);
      items[i].dv = 8'(i + 1);
    end
    u_if.out_ready = 1'b1;
    while (got < 255 && cycles < 255 * 25) begin
      u_if.in_valid = 1'b1;
      if (u_if.in_ready && sent < 255) begin
        u_if.dividend = items[sent].dd;
        u_if.divisor  = items[sent].dv;
      end else begin
        u_if.dividend = 16'($urandom);
        u_if.divisor  = 8'($urandom);
        if (sent >= 255) u_if.in_valid = 1'b0;
      end
      acc = u_if.in_valid && u_if.in_ready;
      hs  = u_if.out_valid && u_if.out_ready;
      q   = u_if.quotient;
      r   = u_if.remainder;
      dz  = u_if.div_zero;
      tick;
      cycles++;
      if (acc) begin
        exp_q.push_back(items[sent]);
        sent++;
      end
      if (hs) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL b2b_extra_result: got q=%0d r=%0d with no pending request", q, r);
        end else begin
          e = exp_q.pop_front();
          got++;
          n_checks++;
          if (q !== 16'(e.dd / e.dv) || r !== 8'(e.dd % e.dv) || dz !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_result %0d/%0d: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=0",
                     e.dd, e.dv, q, r, dz, e.dd / e.dv, e.dd % e.dv);
          end
          n_checks++;
          if (!(r < e.dv) || (int'(q) * int'(e.dv) + int'(r)) != int'(e.dd)) begin
            n_errors++;
            $display("FAIL b2b_identity %0d/%0d: got q=%0d r=%0d, want r<divisor and q*divisor+r=dividend",
                     e.dd, e.dv, q, r);
          end
        end
      end
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    n_checks++;
    if (sent != 255 || got != 255 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_counts: got sent=%0d results=%0d pending=%0d want 255/255/0", sent, got, exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_boundary;
    test_div_zero;
    test_reset_mid;
    test_hold;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
